// File: rtl/user_reg_pkg.sv
// rtl/user_reg_pkg.sv - word/bit indices and FSM state type for the user register bank
package user_reg_pkg;

  localparam int CTRL_ADDR   = 0;
  localparam int STATUS_ADDR = 1;
  localparam int USER_BASE   = 2;

  localparam int CTRL_START       = 0;
  localparam int CTRL_IRQ_EN_DONE = 1;
  localparam int CTRL_IRQ_EN_TO   = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } user_fsm_t;

  // A disabled timeout still needs a 1-bit counter to keep the declaration legal.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/axi_user_reg_bank_if.sv
// rtl/axi_user_reg_bank_if.sv - write beat, readback, and accelerator handshake bundle
interface axi_user_reg_bank_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int WORD_ADDR_WIDTH = 4,
  parameter int N_REGS          = 8
);

  logic                           valid_i;
  logic [WORD_ADDR_WIDTH-1:0]     word_addr_i;
  logic [DATA_WIDTH-1:0]          data_i;
  logic [STRB_WIDTH-1:0]          strb_i;
  logic [WORD_ADDR_WIDTH-1:0]     rd_addr_i;
  logic [DATA_WIDTH-1:0]          rd_data_o;
  logic                           done_i;
  logic                           start_o;
  logic                           busy_o;
  logic                           irq_o;
  logic [(N_REGS-2)*DATA_WIDTH-1:0] user_regs_o;

  modport slave (
    input  valid_i, word_addr_i, data_i, strb_i, rd_addr_i, done_i,
    output rd_data_o, start_o, busy_o, irq_o, user_regs_o
  );

  modport master (
    output valid_i, word_addr_i, data_i, strb_i, rd_addr_i, done_i,
    input  rd_data_o, start_o, busy_o, irq_o, user_regs_o
  );

endinterface

// File: rtl/user_reg_timer.sv
// rtl/user_reg_timer.sv - IDLE/BUSY sequencer with start pulse and saturating timeout counter
module user_reg_timer
  import user_reg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic done_i,
  output logic busy,
  output logic start_pulse,
  output logic done_set,
  output logic to_set
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES);

  user_fsm_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pulse_q, pulse_d;
  logic            timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  end

  // done_i takes priority over a coincident timeout; START while BUSY is ignored.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pulse_d  = 1'b0;
    done_set = 1'b0;
    to_set   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
        if (done_i) begin
          done_set = 1'b1;
          state_d  = IDLE;
        end else if (timeout_hit) begin
          to_set  = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  assign busy        = (state_q == BUSY);
  assign start_pulse = pulse_q;

endmodule

// File: rtl/axi_user_reg_bank.sv
// rtl/axi_user_reg_bank.sv - CTRL/STATUS/user register bank with start/done/timeout sequencing and IRQ
module axi_user_reg_bank
  import user_reg_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int WORD_ADDR_WIDTH = 4,
  parameter int N_REGS          = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic              ACLK,
  input  logic              ARESET,
  axi_user_reg_bank_if.slave bus
);

  localparam int N_USER = N_REGS - USER_BASE;
  localparam int AW     = WORD_ADDR_WIDTH;

  logic                  wr_en, wr_ctrl, wr_status;
  logic                  start_req, w1c_done, w1c_to;
  logic                  busy, start_pulse, done_set, to_set;
  logic                  en_done_q, en_to_q, st_done_q, st_to_q, irq_q;
  logic [DATA_WIDTH-1:0] user_q [N_USER];
  logic [DATA_WIDTH-1:0] rd_data;

  always_comb begin
    wr_en     = bus.valid_i && (int'(bus.word_addr_i) < N_REGS);
    wr_ctrl   = wr_en && (bus.word_addr_i == AW'(CTRL_ADDR)) && bus.strb_i[0];
    wr_status = wr_en && (bus.word_addr_i == AW'(STATUS_ADDR)) && bus.strb_i[0];
    start_req = wr_ctrl && bus.data_i[CTRL_START];
    w1c_done  = wr_status && bus.data_i[STAT_DONE];
    w1c_to    = wr_status && bus.data_i[STAT_TIMEOUT];
  end

  user_reg_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk         (ACLK),
    .rst         (ARESET),
    .start       (start_req),
    .done_i      (bus.done_i),
    .busy        (busy),
    .start_pulse (start_pulse),
    .done_set    (done_set),
    .to_set      (to_set)
  );

  // Hardware set beats a same-cycle W1C so a completion is never lost.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      en_done_q <= 1'b0;
      en_to_q   <= 1'b0;
      st_done_q <= 1'b0;
      st_to_q   <= 1'b0;
      irq_q     <= 1'b0;
      for (int i = 0; i < N_USER; i++) user_q[i] <= '0;
    end else begin
      if (wr_ctrl) begin
        en_done_q <= bus.data_i[CTRL_IRQ_EN_DONE];
        en_to_q   <= bus.data_i[CTRL_IRQ_EN_TO];
      end
      st_done_q <= done_set | (st_done_q & ~w1c_done);
      st_to_q   <= to_set | (st_to_q & ~w1c_to);
      irq_q     <= (st_done_q & en_done_q) | (st_to_q & en_to_q);
      for (int i = 0; i < N_USER; i++) begin
        if (wr_en && (bus.word_addr_i == AW'(USER_BASE + i))) begin
          for (int k = 0; k < STRB_WIDTH; k++) begin
            if (bus.strb_i[k]) user_q[i][8*k +: 8] <= bus.data_i[8*k +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (bus.rd_addr_i == AW'(CTRL_ADDR)) begin
      rd_data[CTRL_IRQ_EN_DONE] = en_done_q;
      rd_data[CTRL_IRQ_EN_TO]   = en_to_q;
    end else if (bus.rd_addr_i == AW'(STATUS_ADDR)) begin
      rd_data[STAT_BUSY]    = busy;
      rd_data[STAT_DONE]    = st_done_q;
      rd_data[STAT_TIMEOUT] = st_to_q;
    end else begin
      for (int i = 0; i < N_USER; i++) begin
        if (bus.rd_addr_i == AW'(USER_BASE + i)) rd_data = user_q[i];
      end
    end
  end

  for (genvar g = 0; g < N_USER; g++) begin : g_flat
    assign bus.user_regs_o[g*DATA_WIDTH +: DATA_WIDTH] = user_q[g];
  end

  assign bus.rd_data_o = rd_data;
  assign bus.start_o   = start_pulse;
  assign bus.busy_o    = busy;
  assign bus.irq_o     = irq_q;

endmodule

// File: tb/tb_axi_user_reg_bank.sv
// tb/tb_axi_user_reg_bank.sv - randomized and directed bench for axi_user_reg_bank
module tb_axi_user_reg_bank;

  localparam int DW = 32;
  localparam int SW = 4;
  localparam int AW = 4;
  localparam int NR = 8;
  localparam int TO = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [DW-1:0] mdl [16];

  axi_user_reg_bank_if #(.DATA_WIDTH(DW), .STRB_WIDTH(SW), .WORD_ADDR_WIDTH(AW), .N_REGS(NR)) ifc ();

  axi_user_reg_bank #(
    .DATA_WIDTH(DW), .STRB_WIDTH(SW), .WORD_ADDR_WIDTH(AW), .N_REGS(NR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .bus    (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    ifc.valid_i     = 1'b1;
    ifc.word_addr_i = a;
    ifc.data_i      = d;
    ifc.strb_i      = s;
    step();
    ifc.valid_i = 1'b0;
    if (a >= 2 && a < NR)
      for (int k = 0; k < SW; k++) if (s[k]) mdl[a][8*k +: 8] = d[8*k +: 8];
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
    ifc.rd_addr_i = a;
    #1;
    d = ifc.rd_data_o;
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    n_checks++;
    if ({ifc.start_o, ifc.busy_o, ifc.irq_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 000", {ifc.start_o, ifc.busy_o, ifc.irq_o});
    end
    for (int a = 0; a < 16; a++) begin
      rd(AW'(a), d);
      n_checks++;
      if (d !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_rd[%0d]: got %h expected 00000000", a, d);
      end
    end
  endtask

  task automatic test_strobe_write();
    logic [DW-1:0] d;
    wr(4'd2, 32'hA5A5_A5A5, 4'b0101);
    rd(4'd2, d);
    n_checks++;
    if (d !== 32'h00A5_00A5) begin
      n_fail++;
      $display("FAIL strobe_w2: got %h expected 00a500a5", d);
    end
    wr(4'd12, 32'hDEAD_BEEF, 4'hF);
    rd(4'd12, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL dropped_w12: got %h expected 00000000", d);
    end
  endtask

  task automatic test_random_user();
    logic [DW-1:0] d, exp;
    logic [AW-1:0] a, ra;
    for (int i = 0; i < 40; i++) begin
      a = AW'($urandom_range(2, 15));
      wr(a, $urandom, SW'($urandom_range(0, 15)));
      ra = AW'($urandom_range(2, 15));
      rd(ra, d);
      exp = (ra < NR) ? mdl[ra] : 32'h0;
      n_checks++;
      if (d !== exp) begin
        n_fail++;
        $display("FAIL rand_rd[%0d]: got %h expected %h", ra, d, exp);
      end
    end
    for (int r = 2; r < NR; r++) begin
      n_checks++;
      if (ifc.user_regs_o[(r-2)*DW +: DW] !== mdl[r]) begin
        n_fail++;
        $display("FAIL user_regs_o[%0d]: got %h expected %h", r, ifc.user_regs_o[(r-2)*DW +: DW], mdl[r]);
      end
    end
  endtask

  task automatic test_done_irq();
    logic [DW-1:0] d;
    wr(4'd0, 32'h7, 4'hF);
    n_checks++;
    if ({ifc.start_o, ifc.busy_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL start_pulse: got %b expected 11", {ifc.start_o, ifc.busy_o});
    end
    rd(4'd0, d);
    n_checks++;
    if (d !== 32'h6) begin
      n_fail++;
      $display("FAIL ctrl_rd: got %h expected 00000006", d);
    end
    step();
    n_checks++;
    if (ifc.start_o !== 1'b0) begin
      n_fail++;
      $display("FAIL start_one_cycle: got %b expected 0", ifc.start_o);
    end
    repeat (3) step();
    ifc.done_i = 1'b1;
    step();
    ifc.done_i = 1'b0;
    rd(4'd1, d);
    n_checks++;
    if (d !== 32'h2 || ifc.irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL done_status: got %h irq %b expected 00000002 irq 0", d, ifc.irq_o);
    end
    step();
    n_checks++;
    if (ifc.irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL done_irq: got %b expected 1", ifc.irq_o);
    end
    wr(4'd1, 32'h2, 4'h1);
    step();
    n_checks++;
    if (ifc.irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL done_w1c_irq: got %b expected 0", ifc.irq_o);
    end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] d;
    int busy_n;
    wr(4'd0, 32'h7, 4'hF);
    busy_n = ifc.busy_o ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      if (!ifc.busy_o) break;
      step();
      if (ifc.busy_o) busy_n++;
    end
    n_checks++;
    if (busy_n !== TO) begin
      n_fail++;
      $display("FAIL timeout_busy_len: got %0d expected %0d", busy_n, TO);
    end
    rd(4'd1, d);
    n_checks++;
    if (d !== 32'h4) begin
      n_fail++;
      $display("FAIL timeout_status: got %h expected 00000004", d);
    end
    step();
    n_checks++;
    if (ifc.irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_irq: got %b expected 1", ifc.irq_o);
    end
    wr(4'd1, 32'h4, 4'h1);
    step();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    int busy_n;
    wr(4'd0, 32'h7, 4'hF);
    busy_n = ifc.busy_o ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      if (!ifc.busy_o) break;
      if (i == 2) begin
        ifc.valid_i = 1'b1; ifc.word_addr_i = 4'd0; ifc.data_i = 32'h7; ifc.strb_i = 4'hF;
      end
      step();
      if (i == 2) begin
        ifc.valid_i = 1'b0;
        n_checks++;
        if (ifc.start_o !== 1'b0) begin
          n_fail++;
          $display("FAIL restart_pulse: got %b expected 0", ifc.start_o);
        end
      end
      if (ifc.busy_o) busy_n++;
    end
    n_checks++;
    if (busy_n !== TO) begin
      n_fail++;
      $display("FAIL restart_busy_len: got %0d expected %0d", busy_n, TO);
    end
    wr(4'd1, 32'h6, 4'h1);
    step();
    wr(4'd0, 32'h7, 4'hF);
    repeat (TO - 1) step();
    ifc.done_i = 1'b1;
    step();
    ifc.done_i = 1'b0;
    rd(4'd1, d);
    n_checks++;
    if (d !== 32'h2) begin
      n_fail++;
      $display("FAIL done_vs_timeout: got %h expected 00000002", d);
    end
    wr(4'd1, 32'h6, 4'h1);
    step();
  endtask

  task automatic test_collision();
    logic [DW-1:0] d;
    wr(4'd0, 32'h7, 4'hF);
    step();
    ifc.valid_i = 1'b1; ifc.word_addr_i = 4'd1; ifc.data_i = 32'h2; ifc.strb_i = 4'h1;
    ifc.done_i  = 1'b1;
    step();
    ifc.valid_i = 1'b0;
    ifc.done_i  = 1'b0;
    rd(4'd1, d);
    n_checks++;
    if (d !== 32'h2) begin
      n_fail++;
      $display("FAIL set_beats_w1c: got %h expected 00000002", d);
    end
    wr(4'd1, 32'h2, 4'h1);
    step();
    wr(4'd0, 32'h1, 4'h0);
    n_checks++;
    if ({ifc.start_o, ifc.busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL strb0_no_start: got %b expected 00", {ifc.start_o, ifc.busy_o});
    end
    rd(4'd0, d);
    n_checks++;
    if (d !== 32'h6) begin
      n_fail++;
      $display("FAIL strb0_ctrl_kept: got %h expected 00000006", d);
    end
  endtask

  task automatic test_reset_busy();
    logic [DW-1:0] d;
    wr(4'd3, 32'h1234_5678, 4'hF);
    wr(4'd0, 32'h7, 4'hF);
    step();
    ifc.done_i = 1'b1;
    step();
    ifc.done_i = 1'b0;
    step();
    wr(4'd0, 32'h7, 4'hF);
    n_checks++;
    if ({ifc.irq_o, ifc.busy_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL pre_reset_state: got %b expected 11", {ifc.irq_o, ifc.busy_o});
    end
    step();
    rst = 1'b1;
    #2;
    n_checks++;
    if ({ifc.start_o, ifc.busy_o, ifc.irq_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL midbusy_reset_outputs: got %b expected 000", {ifc.start_o, ifc.busy_o, ifc.irq_o});
    end
    n_checks++;
    if (ifc.user_regs_o !== '0) begin
      n_fail++;
      $display("FAIL midbusy_reset_user: got %h expected 0", ifc.user_regs_o);
    end
    for (int a = 0; a < NR; a++) begin
      rd(AW'(a), d);
      n_checks++;
      if (d !== 32'h0) begin
        n_fail++;
        $display("FAIL midbusy_reset_rd[%0d]: got %h expected 00000000", a, d);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    ifc.valid_i     = 1'b0;
    ifc.word_addr_i = '0;
    ifc.data_i      = '0;
    ifc.strb_i      = '0;
    ifc.rd_addr_i   = '0;
    ifc.done_i      = 1'b0;
    test_reset();
    test_strobe_write();
    test_random_user();
    test_done_irq();
    test_timeout();
    test_back_to_back();
    test_collision();
    test_reset_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
